// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared types and constants for the instruction sequencer.
//  - seq_state_e : sequencer FSM state encoding (ST_BRK exists only when
//                  INSTR_SEQ_BREAKPOINT_EN is defined)
//  - instruction field positions and the opcodes benches use to build programs
//  - opc_of()    : extracts the opcode field from an instruction word
package instr_seq_pkg;

`ifdef INSTR_SEQ_BREAKPOINT_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5,
    ST_BRK   = 3'd6
  } seq_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5
  } seq_state_e;
`endif

  // Instruction word layout: opcode[15:13], rx[12:10], ry[9:7], imm[9:0]
  localparam int OPC_MSB = 15;
  localparam int RX_MSB  = 12;
  localparam int RY_MSB  = 9;
  localparam int IMM_W   = 10;

  localparam logic [2:0] OPC_MVI    = 3'b101;
  localparam logic [2:0] OPC_ADD    = 3'b010;
  localparam logic [2:0] OPC_MV_OUT = 3'b100;

  function automatic logic [2:0] opc_of(input logic [15:0] w);
    return w[OPC_MSB -: 3];
  endfunction

endpackage

// File: rtl/instr_seq_if.sv
// instr_seq_if: program-load port plus processor-side iin/run/done handshake
// of the instruction sequencer.
//  master : program loader / processor side (drives wr_*, prog_len, start,
//           abort, done; observes iin, run, pc, busy, halted, err)
//  slave  : the sequencer itself
// With INSTR_SEQ_BREAKPOINT_EN defined, bp_en / bp_addr are added (master
// drives them).
interface instr_seq_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic              abort;
  logic              done;
  logic [DATA_W-1:0] iin;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              err;
`ifdef INSTR_SEQ_BREAKPOINT_EN
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
`endif

  modport master (
`ifdef INSTR_SEQ_BREAKPOINT_EN
    output bp_en, bp_addr,
`endif
    output wr_en, wr_addr, wr_data, prog_len, start, abort, done,
    input  iin, run, pc, busy, halted, err
  );

  modport slave (
`ifdef INSTR_SEQ_BREAKPOINT_EN
    input  bp_en, bp_addr,
`endif
    input  wr_en, wr_addr, wr_data, prog_len, start, abort, done,
    output iin, run, pc, busy, halted, err
  );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// prog_mem: program store, DATA_W x 2**ADDR_W, one write port and one
// registered read port.
//  clock, resetn   : clock / async active-low reset (read register only;
//                    array contents are never reset)
//  wr_en_i/_addr_i/_data_i : synchronous write
//  rd_en_i, rd_addr_i      : load rd_data_o from mem[rd_addr_i] on the edge
//  rd_data_o               : read register, holds its value when rd_en_i=0
module prog_mem #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // The sequencer never reads and writes on the same edge (writes only when
  // idle/halted, reads only while fetching), so no bypass is needed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      rd_q <= '0;
    else if (rd_en_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: feeds a stored program one instruction at a time to the
// processor. Each word is fetched into iin, announced with a 1-cycle run
// strobe, and the sequencer then waits for the processor's done pulse.
//  clock, resetn : system clock, async active-low reset
//  bus (slave)   : program write port (wr_en/wr_addr/wr_data), prog_len,
//                  start, abort, done in; iin, run, pc, busy, halted, err out
// Parameters: ADDR_W (depth 2**ADDR_W), DATA_W, TIMEOUT (WAIT watchdog in
// cycles, 0 disables it).
// Optional: INSTR_SEQ_BREAKPOINT_EN adds bp_en/bp_addr and a BRK state that
// stops before issuing the word at bp_addr until start resumes it.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input logic        clock,
  input logic        resetn,
  instr_seq_if.slave bus
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Program length is clamped to the memory depth so pc can never wrap.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              mem_we;
  logic              rd_en;
  logic              last_w;
  logic [DATA_W-1:0] iin_w;

  assign last_w = ({1'b0, pc_q} == (len_q - 1'b1));

`ifdef INSTR_SEQ_BREAKPOINT_EN
  logic bp_hit;
  assign bp_hit = bus.bp_en && (pc_q == bus.bp_addr);
`endif

  // The read register of the RAM is iin itself: it only loads in FETCH (or
  // on a BRK resume), which keeps iin stable through ISSUE and WAIT.
  prog_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_prog_mem (
    .clock     (clock),
    .resetn    (resetn),
    .wr_en_i   (mem_we),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (pc_q),
    .rd_data_o (iin_w)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    wdog_d  = wdog_q;
    mem_we  = 1'b0;
    rd_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT, ST_ERR: begin
        // Writes commit on the same edge start is taken, so FETCH sees them.
        mem_we = bus.wr_en;
        if (bus.start) begin
          if (bus.prog_len != '0) begin
            len_d   = (bus.prog_len > DEPTH) ? DEPTH : bus.prog_len;
            pc_d    = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_HALT;
          end
        end
      end

      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_ISSUE;
`ifdef INSTR_SEQ_BREAKPOINT_EN
        if (bp_hit) begin
          rd_en   = 1'b0;
          state_d = ST_BRK;
        end
`endif
      end

      ST_ISSUE: begin
        // done in this cycle belongs to no instruction yet and is dropped.
        wdog_d  = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.done) begin
          if (last_w) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_FETCH;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
          if ((TIMEOUT != 0) && (wdog_q == WD_W'(TIMEOUT - 1))) state_d = ST_ERR;
        end
      end

`ifdef INSTR_SEQ_BREAKPOINT_EN
      // Resume loads the word directly and skips FETCH, so the breakpoint
      // on this pc is not taken a second time.
      ST_BRK: begin
        if (bus.start) begin
          rd_en   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // abort wins over everything; pc/iin are left as they are for debug.
    if (bus.abort) begin
      state_d = ST_IDLE;
      pc_d    = pc_q;
      len_d   = len_q;
      wdog_d  = wdog_q;
      rd_en   = 1'b0;
    end
  end

  // run is decoded from state so it drops immediately on async reset.
  assign bus.run    = (state_q == ST_ISSUE) && !bus.abort;
  assign bus.iin    = iin_w;
  assign bus.pc     = pc_q;
  assign bus.halted = (state_q == ST_HALT);
  assign bus.err    = (state_q == ST_ERR);
`ifdef INSTR_SEQ_BREAKPOINT_EN
  assign bus.busy   = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                      (state_q == ST_WAIT)  || (state_q == ST_BRK);
`else
  assign bus.busy   = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                      (state_q == ST_WAIT);
`endif

endmodule
